// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: steps a 4:1 mux through enabled channels, settles each, and snapshots y.
module mux4_scan_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);
  localparam logic [3:0] SET = 4'(SETTLE);
  typedef enum logic [1:0] {IDLE, SETTLE_WAIT, FINISH} state_t;
  state_t state;
  logic [3:0] mask_q, shadow, shadow_nx, cnt, above;
  logic [1:0] ch, nxt, first;
  logic has_nxt;
  assign ch = {s0, s1};
  always_comb begin
    first = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    above = mask_q & (4'b1110 << ch);
    has_nxt = |above;
    nxt = above[1] ? 2'd1 : above[2] ? 2'd2 : 2'd3;
    shadow_nx = shadow;
    shadow_nx[ch] = y_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s0     <= 1'b0;
      s1     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sample <= 4'b0;
      shadow <= 4'b0;
      mask_q <= 4'b0;
      cnt    <= 4'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mask_q <= mask;
          shadow <= 4'b0;
          if (|mask) begin
            {s0, s1} <= first;
            cnt      <= SET;
            busy     <= 1'b1;
            state    <= SETTLE_WAIT;
          end else state <= FINISH;
        end
        SETTLE_WAIT: if (cnt == 4'd1) begin
          // capture the settled channel; the last capture publishes the snapshot
          shadow <= shadow_nx;
          if (has_nxt) begin
            {s0, s1} <= nxt;
            cnt      <= SET;
          end else begin
            sample <= shadow_nx;
            busy   <= 1'b0;
            done   <= 1'b1;
            cnt    <= 4'd0;
            state  <= IDLE;
          end
        end else cnt <= cnt - 4'd1;
        FINISH: begin
          sample <= 4'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb_mux4_scan_sequencer: directed checks of scan order, timing, masking, handshake and reset.
module tb_mux4_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] d = 4'b0;
  logic [2:0] st = 3'b0;
  logic [2:0] s0v, s1v, bz, dn, y;
  logic [3:0] mk [3];
  logic [3:0] smp [3];
  int tests = 0;
  int fails = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux4_scan_sequencer #(.SETTLE(g == 0 ? 2 : g == 1 ? 1 : 15)) dut (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .mask(mk[g]), .y_in(y[g]),
      .s0(s0v[g]), .s1(s1v[g]), .busy(bz[g]), .done(dn[g]), .sample(smp[g])
    );
    assign y[g] = d[{s0v[g], s1v[g]}];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_scan(input int i, input logic [3:0] m, output int lat,
                          output logic [15:0] hist, output logic busy_any);
    mk[i] = m;
    st[i] = 1'b1;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    lat = 0;
    hist = {14'b0, s0v[i], s1v[i]};
    busy_any = bz[i];
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (dn[i]) break;
      hist = {hist[13:0], s0v[i], s1v[i]};
      busy_any |= bz[i];
    end
  endtask
  initial begin
    int lat, n, nd, first;
    logic [15:0] hist;
    logic ba;
    for (int i = 0; i < 3; i++) mk[i] = 4'b0;
    #12;
    check("rst_sel", {s0v[0], s1v[0]}, 2'b00);
    check("rst_busy", bz[0], 1'b0);
    check("rst_done", dn[0], 1'b0);
    check("rst_sample", smp[0], 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d = 4'b1010;
    run_scan(0, 4'b1111, lat, hist, ba);
    check("t2_lat", lat, 8);
    check("t2_sel_seq", hist, 16'h05AF);
    check("t2_sample", smp[0], 4'b1010);
    check("t2_busy_seen", ba, 1'b1);
    check("t2_busy_at_done", bz[0], 1'b0);
    @(posedge clk);
    #1;
    check("t2_done_width", dn[0], 1'b0);
    mk[0] = 4'b1111;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t1_busy_before", bz[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("t1_sel", {s0v[0], s1v[0]}, 2'b00);
    check("t1_busy", bz[0], 1'b0);
    check("t1_done", dn[0], 1'b0);
    check("t1_sample", smp[0], 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      nd += int'(dn[0]);
    end
    check("t1_no_done", nd, 0);
    d = 4'b1111;
    run_scan(0, 4'b0101, lat, hist, ba);
    check("t3_lat", lat, 4);
    check("t3_sel_seq", hist, 16'h000A);
    check("t3_sample", smp[0], 4'b0101);
    run_scan(0, 4'b0000, lat, hist, ba);
    check("t4_lat", lat, 1);
    check("t4_busy", ba, 1'b0);
    check("t4_sample", smp[0], 4'b0000);
    d = 4'b1010;
    mk[0] = 4'b1111;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    n = 3;
    nd = 0;
    first = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (dn[0]) begin
        nd++;
        if (first == 0) first = n;
      end
    end
    check("t5_one_done", nd, 1);
    check("t5_done_time", first, 8);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!dn[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_hold_lat", n, 8);
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    check("t5_restart_busy", bz[0], 1'b1);
    check("t5_restart_done_low", dn[0], 1'b0);
    n = 0;
    while (!dn[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_second_lat", n, 8);
    check("t5_sample", smp[0], 4'b1010);
    d = 4'b1000;
    run_scan(1, 4'b1000, lat, hist, ba);
    check("t6_s1_lat", lat, 1);
    check("t6_s1_sample", smp[1], 4'b1000);
    run_scan(2, 4'b1000, lat, hist, ba);
    check("t6_s15_lat", lat, 15);
    check("t6_s15_sample", smp[2], 4'b1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
